// File: rtl/serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int MAX_WIDTH = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand load / start handshake and result bus of the serial subtractor.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             load_x;
   logic             load_y;
   logic [WIDTH-1:0] data_in;
   logic             borrow_in;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] z;
   logic             borrow_out;

   modport master (
      output load_x, load_y, data_in, borrow_in, start,
      input  busy, done, z, borrow_out
   );

   modport slave (
      input  load_x, load_y, data_in, borrow_in, start,
      output busy, done, z, borrow_out
   );
endinterface

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = x - y - b_in, b_out is the borrow.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic b_in,
   output logic d,
   output logic b_out
);
   assign d     = x ^ y ^ b_in;
   assign b_out = (~x & y) | (~(x ^ y) & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: z = x - y - borrow_in, LSB first, one bit per clock
// through a single full-subtractor cell.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   serial_subtractor_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("serial_subtractor: WIDTH out of range");
   end

   state_t           state, state_next;
   logic [WIDTH-1:0] x_reg, y_reg;
   logic [WIDTH-1:0] xs, ys, rs, rs_next;
   logic [WIDTH-1:0] z_reg;
   logic             b, b_next, d;
   logic             borrow_reg;
   logic [CW-1:0]    cnt;
   logic             cnt_last;

   full_subtractor u_fs (
      .x    (xs[0]),
      .y    (ys[0]),
      .b_in (b),
      .d    (d),
      .b_out(b_next)
   );

   assign cnt_last = (cnt == CNT_LAST);
   // Shifting {d, rs} keeps this legal when WIDTH is 1.
   assign rs_next  = WIDTH'({d, rs} >> 1);

   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (cnt_last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking for all clocked state so every register sees pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_reg      <= '0;
         y_reg      <= '0;
         xs         <= '0;
         ys         <= '0;
         rs         <= '0;
         b          <= 1'b0;
         cnt        <= '0;
         z_reg      <= '0;
         borrow_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.load_x) x_reg <= bus.data_in;
               if (bus.load_y) y_reg <= bus.data_in;
               // The pre-edge operands are captured; a simultaneous load is for the next op.
               if (bus.start) begin
                  xs  <= x_reg;
                  ys  <= y_reg;
                  b   <= bus.borrow_in;
                  cnt <= '0;
               end
            end
            RUN: begin
               xs  <= xs >> 1;
               ys  <= ys >> 1;
               rs  <= rs_next;
               b   <= b_next;
               cnt <= cnt + CW'(1);
               if (cnt_last) begin
                  z_reg      <= rs_next;
                  borrow_reg <= b_next;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = (state == RUN);
   assign bus.done       = (state == DONE);
   assign bus.z          = z_reg;
   assign bus.borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand-written corner
// sequences and randomized operands against an arithmetic reference model.
module tb_serial_subtractor;
   localparam int W = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         bi;
      logic [W-1:0] ez;
      logic         eb;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, returns {borrow, difference}.
   function automatic logic [W:0] ref_sub(input int x, input int y, input int bi);
      int diff;
      logic [W-1:0] zz;
      diff = x - y - bi;
      zz   = diff[W-1:0];
      return {(x < y + bi), zz};
   endfunction

   task automatic load(input logic [W-1:0] x, input logic [W-1:0] y);
      bus.data_in = x; bus.load_x = 1'b1;
      tick();
      bus.load_x = 1'b0;
      bus.data_in = y; bus.load_y = 1'b1;
      tick();
      bus.load_y = 1'b0;
   endtask

   // Start one op from IDLE and follow it through RUN and DONE.
   task automatic run_op(input logic bi, input bit ld_at_start, input logic [W-1:0] ld_val,
                         input bit disturb, input logic [W-1:0] ez, input logic eb,
                         input string name);
      bus.start = 1'b1;
      bus.borrow_in = bi;
      if (ld_at_start) begin
         bus.load_x = 1'b1;
         bus.data_in = ld_val;
      end
      tick();
      bus.start = 1'b0;
      bus.load_x = 1'b0;
      for (int i = 0; i < W; i++) begin
         check({name, " busy"}, 32'(bus.busy), 32'd1);
         check({name, " early done"}, 32'(bus.done), 32'd0);
         if (disturb && i == 1) begin
            bus.load_x = 1'b1;
            bus.data_in = 4'd7;
            bus.start = 1'b1;
         end
         tick();
         bus.load_x = 1'b0;
         bus.start = 1'b0;
      end
      check({name, " done"}, 32'(bus.done), 32'd1);
      check({name, " busy at done"}, 32'(bus.busy), 32'd0);
      check({name, " z"}, 32'(bus.z), 32'(ez));
      check({name, " borrow"}, 32'(bus.borrow_out), 32'(eb));
      tick();
      check({name, " done single"}, 32'(bus.done), 32'd0);
      check({name, " idle after"}, 32'(bus.busy), 32'd0);
   endtask

   vec_t vecs[6];
   logic [W:0] r;

   initial begin
      bus.load_x = 1'b0; bus.load_y = 1'b0; bus.data_in = '0;
      bus.borrow_in = 1'b0; bus.start = 1'b0;

      vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 4'd10, 1'b1};
      vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
      vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
      vecs[4] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
      vecs[5] = '{4'd7,  4'd7,  1'b1, 4'd15, 1'b1};

      tick(); tick();
      reset = 1'b0;
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset z", 32'(bus.z), 32'd0);
      check("reset borrow", 32'(bus.borrow_out), 32'd0);

      for (int i = 0; i < 6; i++) begin
         load(vecs[i].x, vecs[i].y);
         run_op(vecs[i].bi, 1'b0, '0, 1'b0, vecs[i].ez, vecs[i].eb, $sformatf("vec%0d", i));
      end

      // Result held across idle cycles with no further done pulse.
      load(4'd3, 4'd9);
      run_op(1'b0, 1'b0, '0, 1'b0, 4'd10, 1'b1, "hold_op");
      begin
         int spurious = 0;
         for (int i = 0; i < 20; i++) begin
            if (bus.done !== 1'b0) spurious++;
            tick();
         end
         check("hold no done", 32'(spurious), 32'd0);
      end
      check("hold z", 32'(bus.z), 32'd10);
      check("hold borrow", 32'(bus.borrow_out), 32'd1);

      // load_x and start during RUN are ignored; x_reg keeps 12 afterwards.
      load(4'd12, 4'd5);
      run_op(1'b0, 1'b0, '0, 1'b1, 4'd7, 1'b0, "run_ignore");
      run_op(1'b0, 1'b0, '0, 1'b0, 4'd7, 1'b0, "x_kept");

      // Load coinciding with start affects only the following op.
      load(4'd8, 4'd1);
      run_op(1'b0, 1'b1, 4'd5, 1'b0, 4'd7, 1'b0, "start_load");
      run_op(1'b0, 1'b0, '0, 1'b0, 4'd4, 1'b0, "after_load");

      // Reset in the second RUN cycle aborts everything, operands included.
      load(4'd10, 4'd3);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort z", 32'(bus.z), 32'd0);
      check("abort borrow", 32'(bus.borrow_out), 32'd0);
      begin
         int spurious = 0;
         for (int i = 0; i < 6; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
            tick();
         end
         check("abort quiet", 32'(spurious), 32'd0);
      end
      run_op(1'b1, 1'b0, '0, 1'b0, 4'd15, 1'b1, "cleared_ops");
      load(4'd10, 4'd3);
      run_op(1'b0, 1'b0, '0, 1'b0, 4'd7, 1'b0, "post_reset");

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] rx, ry;
         logic rb;
         rx = W'($urandom_range(0, (1 << W) - 1));
         ry = W'($urandom_range(0, (1 << W) - 1));
         rb = 1'($urandom_range(0, 1));
         r  = ref_sub(int'(rx), int'(ry), int'(rb));
         load(rx, ry);
         run_op(rb, 1'b0, '0, 1'b0, r[W-1:0], r[W], $sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
